nvm_serial_collector: RTL and testbench
=======================================

Name: nvm_serial_collector

Overview:
- Downstream stage of the NVM reader: consumes the serial bit stream produced by its PISO plus the accompanying address.
- Reassembles each 8-bit word, tags it with its captured address, and buffers {addr,data} pairs in a small first-word-fall-through (FWFT) FIFO.
- Downstream logic drains the FIFO through a valid/ready handshake.
- Reports dropped and aborted frames through sticky status flags.

Parameters:
DATA_W, 8, bits per frame payload; frames are MSB first
ADDR_W, 8, width of captured address
DEPTH, 4, FIFO entries; must be a power of two and at least 2

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
serial_in  input  1  serial data bit
serial_valid  input  1  serial_in carries a valid bit this cycle
frame_start  input  1  this cycle's valid bit is bit DATA_W-1 of a new frame; qualified by serial_valid
address_in  input  ADDR_W  address sampled when frame_start & serial_valid
out_ready  input  1  consumer accepts head entry
out_valid  output  1  FIFO non-empty
data_out  output  DATA_W  head entry data
addr_out  output  ADDR_W  head entry address
fill_level  output  clog2(DEPTH)+1  number of FIFO entries
overflow  output  1  sticky: a completed frame was dropped because the FIFO was full
frame_abort  output  1  sticky: a partial frame was discarded
parity_err  output  1  sticky parity error; see Optional Feature
clear_status  input  1  synchronous clear of all sticky flags

Behaviour:
- Reset (async assert, any cycle):
  - State to IDLE; bit counter, shift register and address latch to 0.
  - FIFO pointers to 0, so out_valid=0 and fill_level=0.
  - data_out=0, addr_out=0, and all sticky flags 0.
  - A frame in progress is lost and is not flagged.
- FSM states: IDLE, RECV.
  - IDLE:
    - serial_valid & frame_start: shift in bit, latch address_in, count=1, go to RECV.
    - serial_valid without frame_start: bit ignored.
  - RECV:
    - Each serial_valid cycle shifts serial_in into the LSB (MSB-first assembly) and increments count.
    - Cycles with serial_valid=0 are stalls; state is held.
    - When the DATA_W-th bit arrives: frame complete, push to FIFO in the same edge, return to IDLE.
    - frame_start & serial_valid in RECV with count<DATA_W: discard the partial frame, set frame_abort, and restart as in IDLE (that bit is the new bit DATA_W-1, address re-latched).
- Push rules:
  - Push occurs at the edge where the final bit is sampled.
  - If the FIFO is full and no pop occurs in that cycle: drop the frame, set overflow, leave contents unchanged.
  - Push and pop in the same cycle with the FIFO full: both succeed; fill_level is unchanged.
- Pop:
  - Occurs when out_valid & out_ready.
  - out_ready while empty has no effect.
  - data_out/addr_out are the registered head entry (FWFT). When empty they hold their last value; they are 0 after reset.
- Latency: final bit sampled at edge N with the FIFO empty → out_valid=1 and data valid after edge N (visible in cycle N+1).
- Pointers: wrap modulo DEPTH; an extra wrap bit distinguishes full from empty.
- Sticky flags:
  - Set and clear are synchronous.
  - clear_status has priority over a simultaneous set.
- Status outputs are registered; no combinational path from inputs to any output.

Optional Feature:
- Macro: NVM_COLLECT_PARITY_EN.
- Defined:
  - A frame is DATA_W+1 bits: DATA_W payload bits, then one even-parity bit over the payload.
  - The push happens when the parity bit is sampled. The parity bit itself is not stored.
  - On mismatch, the word is still pushed and parity_err is set (sticky, cleared by clear_status).
  - frame_start during the parity bit counts as an abort.
- Not defined:
  - A frame is exactly DATA_W bits.
  - parity_err is tied to 0.

Test Plan:
- Reset then frame 0xA5, addr 0x3C, 8 consecutive valid bits 1,0,1,0,0,1,0,1, out_ready=0 → one cycle after the last bit: out_valid=1, data_out=0xA5, addr_out=0x3C, fill_level=1.
- Frame 0x81 with serial_valid low for 3 cycles mid-frame, then drain with out_ready=1 → data_out=0x81; out_valid drops the cycle after the pop; no flags set.
- Send 5 frames (0x01..0x05) with out_ready=0 and DEPTH=4 → fill_level=4, overflow=1, head=0x01; draining yields 0x01..0x04 in order.
- With the FIFO full, complete a frame while out_ready=1 → pop and push both succeed, fill_level stays 4, overflow stays 0.
- frame_start after 3 bits of a frame, then a full frame 0x5A at addr 0x10 → frame_abort=1, single entry 0x5A/0x10; clear_status → frame_abort=0.
- Assert rst mid-frame, release, send frame 0xFF → single entry 0xFF, no sticky flags. With NVM_COLLECT_PARITY_EN, send 0x03 with parity bit 1 → entry 0x03 stored, parity_err=1.

Source files
------------

// File: rtl/nvm_serial_collector.sv
// nvm_serial_collector: reassembles MSB-first serial frames into {addr,data} words buffered in a FWFT FIFO.
// Define NVM_COLLECT_PARITY_EN to expect a trailing even-parity bit per frame and report mismatches.
module nvm_serial_collector #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       serial_in,
    input  logic                       serial_valid,
    input  logic                       frame_start,
    input  logic [ADDR_W-1:0]          address_in,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          data_out,
    output logic [ADDR_W-1:0]          addr_out,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       overflow,
    output logic                       frame_abort,
    output logic                       parity_err,
    input  logic                       clear_status
);
    localparam int PW = $clog2(DEPTH);
`ifdef NVM_COLLECT_PARITY_EN
    localparam int FRAME_W = DATA_W + 1;
`else
    localparam int FRAME_W = DATA_W;
`endif
    // The shifter holds every bit but the one arriving on the completing edge.
    localparam int SW = FRAME_W - 1;
    localparam int CW = $clog2(FRAME_W + 1);

    typedef enum logic {IDLE, RECV} state_t;
    state_t state, state_nx;

    logic [CW-1:0]     cnt;
    logic [SW-1:0]     shreg;
    logic [ADDR_W-1:0] addr_lat;
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [PW:0]       wr_ptr, rd_ptr, wr_nx, rd_nx;
    logic              start, abort, last, full, pop, push, perr;
    logic [DATA_W-1:0] word;

    assign start = serial_valid & frame_start;
    assign abort = start & (state == RECV);
    assign last  = (state == RECV) & serial_valid & ~frame_start & (cnt == CW'(FRAME_W - 1));
`ifdef NVM_COLLECT_PARITY_EN
    assign word = shreg;
    assign perr = ^shreg ^ serial_in;
`else
    assign word = {shreg, serial_in};
    assign perr = 1'b0;
`endif

    assign out_valid  = wr_ptr != rd_ptr;
    assign fill_level = wr_ptr - rd_ptr;
    assign full       = (wr_ptr[PW] != rd_ptr[PW]) & (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop        = out_valid & out_ready;
    assign push       = last & (~full | pop);
    assign wr_nx      = wr_ptr + {{PW{1'b0}}, push};
    assign rd_nx      = rd_ptr + {{PW{1'b0}}, pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        state_nx = start ? RECV : last ? IDLE : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            shreg    <= '0;
            addr_lat <= '0;
        end else if (start) begin
            cnt      <= CW'(1);
            shreg    <= {{(SW-1){1'b0}}, serial_in};
            addr_lat <= address_in;
        end else if (state == RECV && serial_valid) begin
            cnt      <= last ? '0 : cnt + CW'(1);
            shreg    <= {shreg[SW-2:0], serial_in};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr[PW-1:0]] <= word;
            mem_addr[wr_ptr[PW-1:0]] <= addr_lat;
        end
    end

    // Head registers track the entry at the post-edge read pointer; a word
    // pushed into an empty (or just-drained) FIFO bypasses the memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            data_out <= '0;
            addr_out <= '0;
        end else begin
            wr_ptr <= wr_nx;
            rd_ptr <= rd_nx;
            if (wr_nx != rd_nx) begin
                data_out <= (rd_nx == wr_ptr) ? word : mem_data[rd_nx[PW-1:0]];
                addr_out <= (rd_nx == wr_ptr) ? addr_lat : mem_addr[rd_nx[PW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow    <= 1'b0;
            frame_abort <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            overflow    <= clear_status ? 1'b0 : overflow | (last & full & ~pop);
            frame_abort <= clear_status ? 1'b0 : frame_abort | abort;
            parity_err  <= clear_status ? 1'b0 : parity_err | (last & perr);
        end
    end
endmodule

// File: tb/tb_nvm_serial_collector.sv
// tb_nvm_serial_collector: directed and randomized checks of the collector against a queue-based frame model.
module tb_nvm_serial_collector;
    localparam int DW = 8, AW = 8, DEPTH = 4;
`ifdef NVM_COLLECT_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FW = DW + PAR;

    logic clk = 0, rst = 0, serial_in = 0, serial_valid = 0, frame_start = 0, out_ready = 0, clear_status = 0;
    logic [AW-1:0] address_in = 0;
    logic out_valid, overflow, frame_abort, parity_err;
    logic [DW-1:0] data_out;
    logic [AW-1:0] addr_out;
    logic [$clog2(DEPTH):0] fill_level;

    nvm_serial_collector #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
        .frame_start(frame_start), .address_in(address_in), .out_ready(out_ready),
        .out_valid(out_valid), .data_out(data_out), .addr_out(addr_out),
        .fill_level(fill_level), .overflow(overflow), .frame_abort(frame_abort),
        .parity_err(parity_err), .clear_status(clear_status)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    // Model: a frame is a run of FW valid bits opened by frame_start; completed words queue up.
    bit m_in, m_of, m_ab, m_pe;
    int m_nb;
    logic [DW-1:0] m_w;
    logic [AW-1:0] m_a;
    logic [AW+DW-1:0] m_q[$];
    logic [AW+DW-1:0] m_head;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in = 0; m_nb = 0; m_w = 0; m_a = 0; m_q.delete(); m_head = 0;
        m_of = 0; m_ab = 0; m_pe = 0;
    endtask

    task automatic model_step(input bit sv, input bit si, input bit fs, input logic [AW-1:0] ad, input bit rd, input bit cl);
        bit pop, push, sof, sab, spe;
        pop = m_q.size() > 0 && rd;
        push = 0; sof = 0; sab = 0; spe = 0;
        if (sv && fs) begin
            sab = m_in; m_in = 1; m_nb = 1; m_w = DW'(si); m_a = ad;
        end else if (sv && m_in) begin
            m_nb++;
            if (m_nb <= DW) m_w = {m_w[DW-2:0], si};
            else spe = (^m_w) != si;
            if (m_nb == FW) begin
                m_in = 0;
                if (m_q.size() < DEPTH || pop) push = 1;
                else sof = 1;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back({m_a, m_w});
        if (m_q.size() > 0) m_head = m_q[0];
        m_of = cl ? 0 : m_of | sof;
        m_ab = cl ? 0 : m_ab | sab;
        m_pe = cl ? 0 : m_pe | spe;
    endtask

    task automatic compare();
        chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        chk("fill_level", 32'(fill_level), 32'(m_q.size()));
        chk("data_out", 32'(data_out), 32'(m_head[DW-1:0]));
        chk("addr_out", 32'(addr_out), 32'(m_head[AW+DW-1:DW]));
        chk("overflow", 32'(overflow), 32'(m_of));
        chk("frame_abort", 32'(frame_abort), 32'(m_ab));
        chk("parity_err", 32'(parity_err), 32'(m_pe));
    endtask

    task automatic tick(input bit sv, input bit si, input bit fs, input logic [AW-1:0] ad, input bit rd, input bit cl);
        serial_valid = sv; serial_in = si; frame_start = fs; address_in = ad; out_ready = rd; clear_status = cl;
        @(posedge clk);
        model_step(sv, si, fs, ad, rd, cl);
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        @(negedge clk);
        serial_valid = 0; frame_start = 0; out_ready = 0; clear_status = 0;
        rst = 1;
        #2;
        model_reset();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_fill", 32'(fill_level), 0);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_addr", 32'(addr_out), 0);
        chk("rst_flags", {29'd0, overflow, frame_abort, parity_err}, 0);
        @(negedge clk);
        rst = 0;
    endtask

    // Sends a full frame; optional stall before bit index stall_at, optional ready on the last bit.
    task automatic send_frame(input logic [DW-1:0] v, input logic [AW-1:0] ad, input bit pbad, input bit rlast, input int stall_at, input int nstall);
        for (int i = DW - 1; i >= 0; i--) begin
            if (i == stall_at) for (int k = 0; k < nstall; k++) tick(0, 1, 1, 8'hEE, 0, 0);
            tick(1, v[i], i == DW - 1, ad, rlast && PAR == 0 && i == 0, 0);
        end
        if (PAR == 1) tick(1, (^v) ^ pbad, 0, ad, rlast, 0);
    endtask

    initial begin
        model_reset();
        do_reset();
        send_frame(8'hA5, 8'h3C, 0, 0, -1, 0);
        chk("a5_valid", 32'(out_valid), 1);
        chk("a5_data", 32'(data_out), 32'hA5);
        chk("a5_addr", 32'(addr_out), 32'h3C);
        chk("a5_fill", 32'(fill_level), 1);

        do_reset();
        send_frame(8'h81, 8'h22, 0, 0, 4, 3);
        chk("stall_data", 32'(data_out), 32'h81);
        tick(0, 0, 0, 0, 1, 0);
        chk("stall_drained", 32'(out_valid), 0);
        chk("stall_flags", {29'd0, overflow, frame_abort, parity_err}, 0);

        do_reset();
        for (int k = 1; k <= 5; k++) send_frame(DW'(k), AW'(k + 16), 0, 0, -1, 0);
        chk("ovf_fill", 32'(fill_level), 4);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_head", 32'(data_out), 1);
        for (int k = 1; k <= 4; k++) begin
            chk("drain_order", 32'(data_out), 32'(k));
            tick(0, 0, 0, 0, 1, 0);
        end
        chk("drain_empty", 32'(out_valid), 0);

        do_reset();
        for (int k = 1; k <= 4; k++) send_frame(DW'(k), 8'h40, 0, 0, -1, 0);
        send_frame(8'h77, 8'h41, 0, 1, -1, 0);
        chk("full_pp_fill", 32'(fill_level), 4);
        chk("full_pp_ovf", 32'(overflow), 0);
        chk("full_pp_head", 32'(data_out), 2);

        do_reset();
        tick(1, 1, 1, 8'h99, 0, 0);
        tick(1, 0, 0, 8'h99, 0, 0);
        tick(1, 1, 0, 8'h99, 0, 0);
        send_frame(8'h5A, 8'h10, 0, 0, -1, 0);
        chk("abort_flag", 32'(frame_abort), 1);
        chk("abort_fill", 32'(fill_level), 1);
        chk("abort_data", 32'(data_out), 32'h5A);
        chk("abort_addr", 32'(addr_out), 32'h10);
        tick(0, 0, 0, 0, 0, 1);
        chk("abort_clear", 32'(frame_abort), 0);

        do_reset();
        for (int i = 0; i < 4; i++) tick(1, 1, i == 0, 8'h55, 0, 0);
        do_reset();
        send_frame(8'hFF, 8'h01, 0, 0, -1, 0);
        chk("midrst_fill", 32'(fill_level), 1);
        chk("midrst_data", 32'(data_out), 32'hFF);
        chk("midrst_flags", {29'd0, overflow, frame_abort, parity_err}, 0);
        if (PAR == 1) begin
            send_frame(8'h03, 8'h02, 1, 0, -1, 0);
            chk("par_fill", 32'(fill_level), 2);
            chk("par_err", 32'(parity_err), 1);
            tick(0, 0, 0, 0, 1, 0);
            chk("par_data", 32'(data_out), 32'h03);
        end

        for (int c = 0; c < 4000; c++) begin
            int rp;
            rp = (c / 500) % 2 == 0 ? 4 : 1;
            if ($urandom_range(0, 399) == 0) do_reset();
            else tick($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 15) == 0,
                      AW'($urandom), $urandom_range(0, rp) == 0, $urandom_range(0, 49) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
